pipe_mem_stage: RTL and testbench
=================================

Name: pipe_mem_stage

Overview:
- Parametrised memory stage for the pipelined Y86-64 core: data memory, access decode, address-bounds checking and the M->W pipeline register.
- Sits between the execute-stage output register (M inputs) and writeback (W outputs).
- Added over the previous memory block:
  - configurable width and depth
  - correct ret/popq addressing
  - SADR fault detection
  - exception-safe write suppression
  - stall/bubble control of the W register

Parameters:
- DATA_W, 64: data word width in bits; valA/valE/valP/valM width.
- MEM_DEPTH, 256: number of words; the address is a word index.
- INIT_FILE, "": if non-empty, memory is loaded with $readmemh at time 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- m_stat  in  3  status from E/M (1=SAOK, 2=SHLT, 3=SADR, 4=SINS)
- m_icode  in  4  instruction code
- m_valA  in  DATA_W  store data / stack pointer for ret, popq
- m_valE  in  DATA_W  ALU result / address
- m_valP  in  DATA_W  return address for call
- m_dstE  in  4  ALU destination register
- m_dstM  in  4  memory destination register
- wr_kill  in  1  suppress this cycle's write (exception in W)
- w_stall  in  1  hold the W register
- w_bubble  in  1  load NOP into the W register
- m_valM  out  DATA_W  combinational read data for forwarding
- m_stat_out  out  3  combinational stage status for control
- W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  3/4/DATA_W/DATA_W/4/4  registered writeback fields

Behaviour:
Interface (already decided):
- One clock, clk.
- reset is synchronous and active-high.

Access decode:
- Read for icode 5 (mrmovq), 9 (ret), B (popq).
- Write for icode 4 (rmmovq), 8 (call), A (pushq).
- All other icodes perform no access.

Address and write data:
- Address is m_valA for ret and popq; m_valE for mrmovq, rmmovq, call, pushq.
- Write data is m_valP for call; m_valA otherwise.

Bounds check:
- dmem_err = (read or write) and (full DATA_W-bit address >= MEM_DEPTH).
- Compare the full address; no truncation or wrap.

m_valM and status:
- m_valM = mem[addr] when read and not dmem_err; otherwise 0.
- m_stat_out = SADR if dmem_err; otherwise m_stat.

Write commit:
- Occurs at the rising edge iff write, not dmem_err, m_stat==SAOK, not wr_kill, and not reset.
- Exactly one word is written.
- Write commit is independent of w_stall/w_bubble.

Read-during-write:
- m_valM is a combinational array read.
- A same-address read in the same cycle as a write returns pre-write data.
- The new data is visible in the following cycle.

W register (synchronous, priority reset > w_bubble > w_stall > load):
- reset or w_bubble: W_stat=SAOK, W_icode=1 (nop), W_dstE=W_dstM=F (RNONE), W_valE=W_valM=0.
- w_stall: all W fields hold.
- Load: W_stat<=m_stat_out, W_icode<=m_icode, W_valE<=m_valE, W_valM<=m_valM, W_dstE<=m_dstE, W_dstM<=m_dstM.
- Latency: M inputs appear on W outputs one cycle later.

Reset scope:
- Reset does not alter memory contents.
- A write qualified in the reset cycle is dropped.

Optional Feature:
Macro: MEM_DBG_EN.

With MEM_DBG_EN defined:
- Adds input dbg_addr[$clog2(MEM_DEPTH)-1:0].
- Adds output dbg_data[DATA_W-1:0], a combinational read of mem[dbg_addr].
- Adds output wr_count[31:0], which increments on each committed write.
- wr_count resets to 0 and saturates at 0xFFFFFFFF.

Without MEM_DBG_EN:
- These ports and the counter do not exist.
- Behaviour is otherwise identical.

Test Plan:
- rmmovq (icode 4) valE=0x10, valA=0xDEAD, then mrmovq valE=0x10 -> next cycle m_valM=0xDEAD; one cycle later W_valM=0xDEAD, W_stat=1.
- call valE=0x20, valP=0x55, then ret valA=0x20 -> m_valM=0x55; popq with valA=0x20, valE=0x28 also reads 0x55 (valE ignored).
- mrmovq valE=MEM_DEPTH (256) -> m_valM=0, m_stat_out=3, W_stat=3 next cycle. rmmovq valE=0x1_0000_0000 -> no write, m_stat_out=3.
- rmmovq valE=0x30, valA=7 with wr_kill=1; repeat with m_stat=4 -> mem[0x30] unchanged in both cases.
- Load W with valE=0x99, then w_stall=1 for 3 cycles with changing inputs -> W_valE stays 0x99. Then w_bubble=1 -> W_icode=1, W_dstE=F, W_dstM=F, W_valE=0. reset asserted mid-stream -> same bubble values; memory contents preserved.
- MEM_DBG_EN: 3 committed writes plus 1 killed write -> wr_count=3; dbg_addr=0x10 -> dbg_data=0xDEAD.

Source files
------------

// File: rtl/pipe_mem_stage.sv
// Y86-64 memory stage: data memory, access decode, bounds check and M->W register.
// Optional MEM_DBG_EN adds a debug read port and a committed-write counter.
module pipe_mem_stage #(
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 256,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valA,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valP,
  input  logic [3:0]        m_dstE,
  input  logic [3:0]        m_dstM,
  input  logic              wr_kill,
  input  logic              w_stall,
  input  logic              w_bubble,
  output logic [DATA_W-1:0] m_valM,
  output logic [2:0]        m_stat_out,
  output logic [2:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM
`ifdef MEM_DBG_EN
  ,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_data,
  output logic [31:0]                  wr_count
`endif
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(MEM_DEPTH);

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [3:0] INOP = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              rd;
  logic              wr;
  logic              dmem_err;
  logic              wr_en;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [AW-1:0]     idx;

  always_comb begin
    rd = 1'b0;
    wr = 1'b0;
    unique case (m_icode)
      4'h5, 4'h9, 4'hB: rd = 1'b1;
      4'h4, 4'h8, 4'hA: wr = 1'b1;
      default: ;
    endcase
    addr = (m_icode == 4'h9 || m_icode == 4'hB) ? m_valA : m_valE;
    wdata = (m_icode == 4'h8) ? m_valP : m_valA;
    idx = addr[AW-1:0];
    dmem_err = (rd || wr) && (addr >= DEPTH_W);
    m_valM = (rd && !dmem_err) ? mem[idx] : '0;
    m_stat_out = dmem_err ? SADR : m_stat;
    wr_en = wr && !dmem_err && (m_stat == SAOK)
            && !wr_kill && !reset;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
  end

  logic [2:0]        w_stat_d,  w_stat_q;
  logic [3:0]        w_icode_d, w_icode_q;
  logic [DATA_W-1:0] w_vale_d,  w_vale_q;
  logic [DATA_W-1:0] w_valm_d,  w_valm_q;
  logic [3:0]        w_dste_d,  w_dste_q;
  logic [3:0]        w_dstm_d,  w_dstm_q;

  always_comb begin
    w_stat_d  = w_stat_q;
    w_icode_d = w_icode_q;
    w_vale_d  = w_vale_q;
    w_valm_d  = w_valm_q;
    w_dste_d  = w_dste_q;
    w_dstm_d  = w_dstm_q;
    if (w_bubble) begin
      w_stat_d  = SAOK;
      w_icode_d = INOP;
      w_vale_d  = '0;
      w_valm_d  = '0;
      w_dste_d  = RNONE;
      w_dstm_d  = RNONE;
    end else if (!w_stall) begin
      w_stat_d  = m_stat_out;
      w_icode_d = m_icode;
      w_vale_d  = m_valE;
      w_valm_d  = m_valM;
      w_dste_d  = m_dstE;
      w_dstm_d  = m_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_stat_q  <= SAOK;
      w_icode_q <= INOP;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
    end else begin
      w_stat_q  <= w_stat_d;
      w_icode_q <= w_icode_d;
      w_vale_q  <= w_vale_d;
      w_valm_q  <= w_valm_d;
      w_dste_q  <= w_dste_d;
      w_dstm_q  <= w_dstm_d;
    end
  end

  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_valE  = w_vale_q;
  assign W_valM  = w_valm_q;
  assign W_dstE  = w_dste_q;
  assign W_dstM  = w_dstm_q;

`ifdef MEM_DBG_EN
  logic [31:0] wr_count_d, wr_count_q;

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_en && wr_count_q != 32'hFFFF_FFFF)
      wr_count_d = wr_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wr_count_q <= '0;
    else       wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
  assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Randomized bench for pipe_mem_stage against a behavioural memory/W model.
// Directed literal checks pin the model; MEM_DBG_EN checks debug ports.
module tb_pipe_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  m_stat = 3'd1;
    logic [3:0]  m_icode = 4'h1;
    logic [63:0] m_valA = '0;
    logic [63:0] m_valE = '0;
    logic [63:0] m_valP = '0;
    logic [3:0]  m_dstE = 4'hF;
    logic [3:0]  m_dstM = 4'hF;
    logic        wr_kill = 1'b0;
    logic        w_stall = 1'b0;
    logic        w_bubble = 1'b0;
    logic [63:0] m_valM;
    logic [2:0]  m_stat_out;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
`ifdef MEM_DBG_EN
    logic [7:0]  dbg_addr = '0;
    logic [63:0] dbg_data;
    logic [31:0] wr_count;
`endif

    pipe_mem_stage #(.DATA_W(64), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .m_stat(m_stat), .m_icode(m_icode),
        .m_valA(m_valA), .m_valE(m_valE), .m_valP(m_valP),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .wr_kill(wr_kill),
        .w_stall(w_stall), .w_bubble(w_bubble), .m_valM(m_valM),
        .m_stat_out(m_stat_out), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE),
        .W_dstM(W_dstM)
`ifdef MEM_DBG_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    bit mem_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: word array plus expected W contents.
    logic [63:0] mm [256];
    logic [63:0] initv [256];
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic [63:0] e_valE, e_valM;
    logic [3:0]  e_dstE, e_dstM;
    logic [31:0] e_cnt = '0;

    function automatic bit is_rd(input logic [3:0] ic);
        return ic inside {4'h5, 4'h9, 4'hB};
    endfunction

    function automatic bit is_wr(input logic [3:0] ic);
        return ic inside {4'h4, 4'h8, 4'hA};
    endfunction

    function automatic logic [63:0] eff_addr(input logic [3:0] ic,
                                             input logic [63:0] a,
                                             input logic [63:0] e);
        return (ic == 4'h9 || ic == 4'hB) ? a : e;
    endfunction

    function automatic bit bad_addr(input logic [3:0] ic,
                                    input logic [63:0] ad);
        return (is_rd(ic) || is_wr(ic)) && (ad >= 64'd256);
    endfunction

    logic [63:0] p_ad, p_vm;
    logic [2:0]  p_so;

    always @(posedge clk) begin
        p_ad = eff_addr(m_icode, m_valA, m_valE);
        p_vm = (is_rd(m_icode) && !bad_addr(m_icode, p_ad))
               ? mm[p_ad[7:0]] : 64'd0;
        p_so = bad_addr(m_icode, p_ad) ? 3'd3 : m_stat;
        if (is_wr(m_icode) && !bad_addr(m_icode, p_ad) && m_stat == 3'd1
            && !wr_kill && !reset) begin
            mm[p_ad[7:0]] = (m_icode == 4'h8) ? m_valP : m_valA;
            if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
        end
        if (reset) e_cnt = 0;
        if (reset || w_bubble) begin
            e_stat = 3'd1; e_icode = 4'h1; e_valE = 0; e_valM = 0;
            e_dstE = 4'hF; e_dstM = 4'hF;
        end else if (!w_stall) begin
            e_stat = p_so; e_icode = m_icode; e_valE = m_valE;
            e_valM = p_vm; e_dstE = m_dstE; e_dstM = m_dstM;
        end
    end

    logic [63:0] c_ad;

    always @(negedge clk) begin
        if (chk_on) begin
            c_ad = eff_addr(m_icode, m_valA, m_valE);
            chk("m_valM", m_valM,
                (is_rd(m_icode) && !bad_addr(m_icode, c_ad))
                ? mm[c_ad[7:0]] : 64'd0);
            chk("m_stat_out", {61'd0, m_stat_out},
                bad_addr(m_icode, c_ad) ? 64'd3 : {61'd0, m_stat});
            chk("W_stat", {61'd0, W_stat}, {61'd0, e_stat});
            chk("W_icode", {60'd0, W_icode}, {60'd0, e_icode});
            chk("W_valE", W_valE, e_valE);
            chk("W_valM", W_valM, e_valM);
            chk("W_dstE", {60'd0, W_dstE}, {60'd0, e_dstE});
            chk("W_dstM", {60'd0, W_dstM}, {60'd0, e_dstM});
`ifdef MEM_DBG_EN
            chk("wr_count", {32'd0, wr_count}, {32'd0, e_cnt});
            if (mem_ready) chk("dbg_data", dbg_data, mm[dbg_addr]);
`endif
        end
    end

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p = 0, input logic kill = 0,
                         input logic stall = 0, input logic bub = 0,
                         input logic rst = 0);
        @(posedge clk);
        #1;
        m_stat = st; m_icode = ic; m_valA = a; m_valE = e; m_valP = p;
        m_dstE = ic ^ 4'h3; m_dstM = ic ^ 4'h6;
        wr_kill = kill; w_stall = stall; w_bubble = bub; reset = rst;
        @(negedge clk);
    endtask

    logic [63:0] ra, re, rad;
    logic [3:0]  ric;
    logic [2:0]  rst3;

    initial begin
        drive(1, 4'h6, 64'h5, 64'h6, 0, 0, 0, 0, 1);
        drive(1, 4'h1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst W_stat", {61'd0, W_stat}, 64'd1);
        chk("rst W_icode", {60'd0, W_icode}, 64'd1);
        chk("rst W_dstE", {60'd0, W_dstE}, 64'hF);
        chk("rst W_dstM", {60'd0, W_dstM}, 64'hF);
        chk("rst W_valE", W_valE, 64'd0);
        chk_on = 1'b1;

        for (int i = 0; i < 256; i++) begin
            initv[i] = {$urandom, $urandom};
            drive(1, 4'h4, initv[i], 64'(i));
        end
        drive(1, 4'h1, 0, 0);
        mem_ready = 1'b1;

        drive(1, 4'h4, 64'hDEAD, 64'h10);
        drive(1, 4'h5, 64'h0, 64'h10);
        chk("mrmovq valM", m_valM, 64'hDEAD);
        drive(1, 4'h1, 0, 0);
        chk("mrmovq W_valM", W_valM, 64'hDEAD);
        chk("mrmovq W_stat", {61'd0, W_stat}, 64'd1);

        drive(1, 4'h8, 64'h1234, 64'h20, 64'h55);
        drive(1, 4'h9, 64'h20, 64'h999);
        chk("ret valM", m_valM, 64'h55);
        drive(1, 4'hB, 64'h20, 64'h28);
        chk("popq valM", m_valM, 64'h55);

        drive(1, 4'h5, 0, 64'd256);
        chk("oob valM", m_valM, 64'd0);
        chk("oob stat", {61'd0, m_stat_out}, 64'd3);
        drive(1, 4'h1, 0, 0);
        chk("oob W_stat", {61'd0, W_stat}, 64'd3);
        drive(1, 4'h4, 64'h1234, 64'h1_0000_0000);
        chk("huge stat", {61'd0, m_stat_out}, 64'd3);
        drive(1, 4'h5, 0, 64'h0);
        chk("no alias", m_valM, initv[0]);

        drive(1, 4'h4, 64'h7, 64'h30, 0, 1);
        drive(4, 4'h4, 64'h7, 64'h30);
        drive(1, 4'h5, 0, 64'h30);
        chk("killed wr", m_valM, initv[8'h30]);

        drive(1, 4'h6, 0, 64'h99);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'h6, 0, 64'(100 + i), 0, 0, 1);
            chk("stall W_valE", W_valE, 64'h99);
        end
        drive(1, 4'h6, 0, 64'h77, 0, 0, 0, 1);
        drive(1, 4'h6, 0, 64'h78);
        chk("bub W_icode", {60'd0, W_icode}, 64'd1);
        chk("bub W_dstE", {60'd0, W_dstE}, 64'hF);
        chk("bub W_dstM", {60'd0, W_dstM}, 64'hF);
        chk("bub W_valE", W_valE, 64'd0);

        drive(1, 4'h4, 64'hBAD, 64'h40, 0, 0, 0, 0, 1);
        drive(1, 4'h5, 0, 64'h40);
        chk("rst W_icode2", {60'd0, W_icode}, 64'd1);
        chk("rst W_valE2", W_valE, 64'd0);
        chk("rst drop wr", m_valM, initv[8'h40]);
        drive(1, 4'h5, 0, 64'h10);
        chk("mem kept", m_valM, 64'hDEAD);

`ifdef MEM_DBG_EN
        drive(1, 4'h1, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 4'h4, 64'h1, 64'h50);
        drive(1, 4'h4, 64'h2, 64'h51);
        drive(1, 4'hA, 64'h3, 64'h52);
        drive(1, 4'h4, 64'h4, 64'h53, 0, 1);
        drive(1, 4'h1, 0, 0);
        dbg_addr = 8'h10;
        #1;
        chk("dbg wr_count", {32'd0, wr_count}, 64'd3);
        chk("dbg_data", dbg_data, 64'hDEAD);
`endif

        for (int n = 0; n < 2500; n++) begin
            ric = 4'($urandom_range(0, 11));
            rst3 = ($urandom_range(0, 9) == 0)
                   ? 3'($urandom_range(2, 4)) : 3'd1;
            case ($urandom_range(0, 19))
                0: rad = {$urandom, $urandom};
                1: rad = 64'(256 + $urandom_range(0, 3));
                default: rad = 64'($urandom_range(0, 255));
            endcase
            if (ric == 4'h9 || ric == 4'hB) begin
                ra = rad; re = {$urandom, $urandom};
            end else begin
                ra = {$urandom, $urandom}; re = rad;
            end
`ifdef MEM_DBG_EN
            dbg_addr = 8'($urandom_range(0, 255));
`endif
            drive(rst3, ric, ra, re, {$urandom, $urandom},
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
